// File: rtl/scope_capture.sv
// scope_capture: multi-channel oscilloscope capture engine.
// Drives the external ADC channel mux, scales each conversion to a screen row
// and fills per-channel frame buffers under rate-divider and trigger control.
// Optional feature: define SCOPE_TRIG_HYST_EN to require a dip of HYST counts
// below trig_level before each trigger (suppresses noise re-triggers).
//
// state   | meaning
// IDLE    | after reset; nothing stored until arm
// ARMED   | waiting for a rising edge on the trigger channel
// CAPTURE | storing every slot, one column per slot
// DONE    | frame complete; mode decides what follows
module scope_capture #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 640,
    parameter int Y_MAX  = 479,
    parameter int ROW_W  = 10,
    parameter int HYST   = 512,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic [15:0]      adc_data,
    input  logic             adc_valid,
    output logic [CH_W-1:0]  ch_sel,
    input  logic [15:0]      rate_div,
    input  logic [1:0]       mode,
    input  logic [1:0]       trig_ch,
    input  logic [15:0]      trig_level,
    input  logic             arm,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    input  logic [1:0]       rd_ch,
    input  logic [AW-1:0]    rd_addr,
    output logic [ROW_W-1:0] rd_data
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

`ifdef SCOPE_TRIG_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [15:0]      div_cnt_q, div_cnt_d;
    logic             seq_q, seq_d;
    logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic             overrun_q, overrun_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic             hyst_seen_q, hyst_seen_d;
    logic [ROW_W-1:0] rd_data_q;
    logic [ROW_W-1:0] mem_q  [NUM_CH][DEPTH];
    logic [ROW_W-1:0] hold_q [NUM_CH];

    logic             tick, consume, last_ch, trig_sample, rise, trig_hit, store, frame_end;
    logic [CH_W-1:0]  trig_sel;
    logic [15:0]      scaled, low_thr;
    logic [ROW_W-1:0] row_cur;

    assign tick        = (div_cnt_q == rate_div);
    assign consume     = seq_q & adc_valid & ~arm & ~rst;
    assign last_ch     = (ch_sel_q == CH_W'(NUM_CH - 1));
    assign trig_sel    = (32'(trig_ch) < NUM_CH) ? trig_ch[CH_W-1:0] : '0;
    assign trig_sample = consume & (ch_sel_q == trig_sel);

    // Row = Y_MAX - floor(sample * (Y_MAX+1) / 2^16): top of screen is full scale.
    assign scaled  = 16'((32'(adc_data) * 32'(Y_MAX + 1)) >> 16);
    assign row_cur = ROW_W'(32'(Y_MAX) - 32'(scaled));
    assign low_thr = (trig_level > 16'(HYST)) ? trig_level - 16'(HYST) : 16'd0;

    assign rise      = prev_vld_q & (prev_q < trig_level) & (adc_data >= trig_level);
    assign trig_hit  = trig_sample & (state_q == S_ARMED) & rise & (~HYST_EN | hyst_seen_q);
    assign store     = consume & ((state_q == S_CAPTURE) | trig_hit);
    assign frame_end = store & last_ch & (wr_addr_q == AW'(DEPTH - 1));

    // Next-state logic: slot timer, channel sequencer, trigger tracking and FSM.
    always_comb begin
        div_cnt_d    = tick ? 16'd0 : div_cnt_q + 16'd1;
        state_d      = state_q;
        seq_d        = seq_q;
        ch_sel_d     = ch_sel_q;
        wr_addr_d    = wr_addr_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        hyst_seen_d  = hyst_seen_q;

        if (arm) begin
            // A tick coinciding with arm starts a fresh sequence in the new state.
            state_d     = (mode == 2'd0) ? S_CAPTURE : S_ARMED;
            seq_d       = tick;
            ch_sel_d    = '0;
            wr_addr_d   = '0;
            overrun_d   = 1'b0;
            prev_vld_d  = 1'b0;
            hyst_seen_d = 1'b0;
        end else begin
            if (tick) begin
                if (seq_q) begin
                    overrun_d = 1'b1;
                end else begin
                    seq_d    = 1'b1;
                    ch_sel_d = '0;
                end
            end
            if (consume) begin
                if (last_ch) begin
                    seq_d    = 1'b0;
                    ch_sel_d = '0;
                end else begin
                    ch_sel_d = ch_sel_q + CH_W'(1);
                end
            end
            if (trig_sample) begin
                prev_d     = adc_data;
                prev_vld_d = 1'b1;
                if (adc_data <= low_thr) hyst_seen_d = 1'b1;
            end
            case (state_q)
                S_ARMED: begin
                    if (trig_hit) begin
                        state_d     = S_CAPTURE;
                        hyst_seen_d = 1'b0;
                    end
                end
                S_DONE: begin
                    if (mode == 2'd0)      state_d = S_CAPTURE;
                    else if (mode == 2'd1) state_d = S_ARMED;
                end
                default: ;
            endcase
            if (store && last_ch) begin
                if (frame_end) begin
                    state_d      = S_DONE;
                    wr_addr_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    wr_addr_d = wr_addr_q + AW'(1);
                end
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            seq_q        <= 1'b0;
            ch_sel_q     <= '0;
            wr_addr_q    <= '0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            hyst_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            seq_q        <= seq_d;
            ch_sel_q     <= ch_sel_d;
            wr_addr_q    <= wr_addr_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            hyst_seen_q  <= hyst_seen_d;
        end
    end

    // Hold each channel's latest row so a trigger on a later channel can still store the earlier ones.
    always_ff @(posedge clk_100MHz) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (consume && ch_sel_q == CH_W'(c)) hold_q[c] <= row_cur;
        end
    end

    // Frame buffer writes; on trigger the channels sequenced before trig_ch come from hold_q.
    always_ff @(posedge clk_100MHz) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (store && ch_sel_q == CH_W'(c))
                mem_q[c][wr_addr_q] <= row_cur;
            else if (trig_hit && CH_W'(c) < trig_sel)
                mem_q[c][wr_addr_q] <= hold_q[c];
        end
    end

    // Registered read port; out-of-range channel or column reads as 0.
    always_ff @(posedge clk_100MHz) begin
        if (rst)
            rd_data_q <= '0;
        else if (32'(rd_ch) < NUM_CH && 32'(rd_addr) < DEPTH)
            rd_data_q <= mem_q[rd_ch[CH_W-1:0]][rd_addr];
        else
            rd_data_q <= '0;
    end

    assign ch_sel     = ch_sel_q;
    assign busy       = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed bench for scope_capture with default parameters.
// A small ADC model answers ch_sel every cycle (or every adc_gap cycles);
// slot_cnt counts completed ch0 conversions to build ramp and noise patterns.
module tb_scope_capture;

    logic        clk_100MHz = 1'b0;
    logic        rst;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic [0:0]  ch_sel;
    logic [15:0] rate_div;
    logic [1:0]  mode;
    logic [1:0]  trig_ch;
    logic [15:0] trig_level;
    logic        arm;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [1:0]  rd_ch;
    logic [9:0]  rd_addr;
    logic [9:0]  rd_data;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pattern, ramp_ch, adc_gap, slot_cnt, gap_cnt;
    logic [15:0] c0, c1;
    logic [0:0]  prev_sel;

    scope_capture dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .ch_sel     (ch_sel),
        .rate_div   (rate_div),
        .mode       (mode),
        .trig_ch    (trig_ch),
        .trig_level (trig_level),
        .arm        (arm),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .rd_ch      (rd_ch),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] adc_value(input int sel);
        logic [15:0] r;
        r = 16'(1000 * (slot_cnt % 60));
        case (pattern)
            0:       return (sel != 0) ? c1 : c0;
            1:       return (sel == ramp_ch) ? r : ((sel != 0) ? c1 : c0);
            default: return (sel != 0) ? c1 : (((slot_cnt % 2) != 0) ? 16'd32800 : 16'd32700);
        endcase
    endfunction

    // ADC model: pulses adc_valid every adc_gap cycles with data for the current ch_sel.
    initial begin
        adc_valid = 1'b0;
        adc_data  = '0;
        slot_cnt  = 0;
        gap_cnt   = 0;
        prev_sel  = '0;
        forever begin
            @(negedge clk_100MHz);
            if (prev_sel == 1'b0 && ch_sel != 1'b0) slot_cnt++;
            prev_sel = ch_sel;
            gap_cnt++;
            if (gap_cnt >= adc_gap) begin
                adc_valid = 1'b1;
                gap_cnt   = 0;
            end else begin
                adc_valid = 1'b0;
            end
            adc_data = adc_value(int'(ch_sel));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic pulse_arm();
        @(negedge clk_100MHz);
        arm = 1'b1;
        @(negedge clk_100MHz);
        arm = 1'b0;
    endtask

    task automatic rd_word(input int ch, input int addr, output int val);
        @(negedge clk_100MHz);
        rd_ch   = 2'(ch);
        rd_addr = 10'(addr);
        @(negedge clk_100MHz);
        val = int'(rd_data);
    endtask

    task automatic wait_frame(input int budget, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100MHz);
            if (frame_done) begin
                seen = 1'b1;
                n    = i;
                break;
            end
        end
    endtask

    initial begin
        int v, n, pulses;
        bit seen;

        rst        = 1'b1;
        arm        = 1'b0;
        mode       = 2'd0;
        rate_div   = 16'd9;
        trig_ch    = 2'd0;
        trig_level = 16'd32768;
        rd_ch      = 2'd0;
        rd_addr    = '0;
        pattern    = 0;
        ramp_ch    = 0;
        adc_gap    = 1;
        c0         = 16'd0;
        c1         = 16'hFFFF;

        cycles(3);
        check_val("rst_ch_sel", int'(ch_sel), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_frame_done", int'(frame_done), 0);
        check_val("rst_overrun", int'(overrun), 0);
        check_val("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        cycles(5);
        check_val("idle_busy", int'(busy), 0);

        // Free-run: ch0 = 0 -> row 479, ch1 = 65535 -> row 0.
        mode = 2'd0;
        pulse_arm();
        check_val("fr_busy", int'(busy), 1);
        wait_frame(7000, seen, n);
        check_val("fr_frame_seen", int'(seen), 1);
        check_val("fr_frame_len_ok", int'(n >= 6391 && n <= 6400), 1);
        check_val("fr_busy_done", int'(busy), 0);
        cycles(1);
        check_val("fr_fd_one_cycle", int'(frame_done), 0);
        check_val("fr_restart", int'(busy), 1);
        rd_word(0, 0, v);   check_val("fr_ch0_a0", v, 479);
        rd_word(0, 320, v); check_val("fr_ch0_a320", v, 479);
        rd_word(0, 639, v); check_val("fr_ch0_a639", v, 479);
        rd_word(1, 0, v);   check_val("fr_ch1_a0", v, 0);
        rd_word(1, 639, v); check_val("fr_ch1_a639", v, 0);

        // Reset around column 300 with swapped values; old columns must survive.
        c0 = 16'hFFFF;
        c1 = 16'd0;
        pulse_arm();
        cycles(3000);
        @(negedge clk_100MHz);
        rst = 1'b1;
        @(negedge clk_100MHz);
        check_val("mr_busy", int'(busy), 0);
        check_val("mr_ch_sel", int'(ch_sel), 0);
        check_val("mr_frame_done", int'(frame_done), 0);
        check_val("mr_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        cycles(2);
        check_val("mr_idle_busy", int'(busy), 0);
        rd_word(0, 10, v);  check_val("mr_ch0_new", v, 0);
        rd_word(0, 500, v); check_val("mr_ch0_old", v, 479);
        rd_word(1, 10, v);  check_val("mr_ch1_new", v, 479);
        rd_word(1, 500, v); check_val("mr_ch1_old", v, 0);

        // Overrun: slow ADC makes a slot's sequence outlast the slot period.
        c0 = 16'd0;
        c1 = 16'hFFFF;
        pulse_arm();
        cycles(100);
        check_val("ov_clear_fast", int'(overrun), 0);
        adc_gap = 25;
        cycles(200);
        check_val("ov_set_slow", int'(overrun), 1);
        adc_gap = 1;
        cycles(100);
        check_val("ov_sticky", int'(overrun), 1);
        pulse_arm();
        check_val("ov_arm_clears", int'(overrun), 0);

        // Single-shot, ch0 ramp, trig_ch 3 falls back to ch0: 33000 -> row 238.
        mode    = 2'd2;
        trig_ch = 2'd3;
        pattern = 1;
        ramp_ch = 0;
        c1      = 16'd20000;
        pulse_arm();
        check_val("ss_armed_busy", int'(busy), 1);
        wait_frame(8000, seen, n);
        check_val("ss_frame_seen", int'(seen), 1);
        pulses = 0;
        repeat (200) begin
            @(negedge clk_100MHz);
            if (frame_done) pulses++;
        end
        check_val("ss_no_refire", pulses, 0);
        check_val("ss_done_busy", int'(busy), 0);
        rd_word(0, 0, v); check_val("ss_ch0_c0", v, 238);
        rd_word(0, 1, v); check_val("ss_ch0_c1", v, 230);
        rd_word(1, 0, v); check_val("ss_ch1_c0", v, 333);

        // Noise around the level triggers on the first crossing (32800 -> 239).
        pattern = 2;
        trig_ch = 2'd0;
        pulse_arm();
        cycles(200);
        check_val("nz_busy", int'(busy), 1);
        rd_word(0, 0, v); check_val("nz_ch0_c0", v, 239);
        rd_word(0, 1, v); check_val("nz_ch0_c1", v, 240);

        // Auto mode, trigger on ch1 ramp: ch0 of the trigger slot comes from the hold path.
        mode    = 2'd1;
        trig_ch = 2'd1;
        pattern = 1;
        ramp_ch = 1;
        c0      = 16'd40000;
        pulse_arm();
        cycles(1000);
        rd_word(1, 0, v); check_val("au_ch1_c0", v, 238);
        rd_word(0, 0, v); check_val("au_ch0_c0", v, 187);
        rd_word(1, 1, v); check_val("au_ch1_c1", v, 230);
        rd_word(0, 1, v); check_val("au_ch0_c1", v, 187);
        wait_frame(7000, seen, n);
        check_val("au_frame_seen", int'(seen), 1);
        check_val("au_done_busy", int'(busy), 0);
        cycles(1);
        check_val("au_rearm_busy", int'(busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
